// File: rtl/rr_operand_mux_if.sv
// Operand-selector bus: per-channel source handshakes, one registered
// output toward the multiplier load port, and the arbiter's last grant.
interface rr_operand_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  // Handshake: a transfer happens on a rising clk edge when valid and ready
  // are both high. A source holds valid/data until it sees ready. in_ready
  // may depend combinationally on out_ready, never on its own in_valid alone.
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          last_grant;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid, last_grant
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid, last_grant
  );
endinterface

// File: rtl/rr_operand_mux.sv
// Registered N:1 operand selector with fixed-select or round-robin grant and
// a one-entry output register that can reload in the cycle it is drained.
module rr_operand_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic clk,
  input  logic rst,
  rr_operand_mux_if.slave bus
);

  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_chan;
  logic                r_out_valid;
  logic [SEL_W-1:0]    r_last_grant;

  logic                w_space;
  logic [CHANNELS-1:0] w_grant;
  logic [SEL_W-1:0]    w_grant_idx;
  logic                w_grant_any;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic [WIDTH-1:0]    w_sel_data;

  assign w_space = ~r_out_valid | bus.out_ready;

  // Round-robin walks offsets from farthest to nearest so the channel
  // closest after last_grant is the one left standing.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant     = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    if (bus.mode == 1'b0) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if ((int'(bus.sel) == k) && bus.in_valid[k]) begin
          w_grant[k]  = 1'b1;
          w_grant_idx = SEL_W'(k);
          w_grant_any = 1'b1;
        end
      end
    end else begin
      for (int off = CHANNELS; off >= 1; off--) begin
        idx = (int'(r_last_grant) + off) % CHANNELS;
        if (bus.in_valid[idx]) begin
          w_grant      = '0;
          w_grant[idx] = 1'b1;
          w_grant_idx  = SEL_W'(idx);
          w_grant_any  = 1'b1;
        end
      end
    end
  end

  assign w_sel_data = bus.in_data[int'(w_grant_idx)*WIDTH +: WIDTH];
  assign w_in_xfer  = w_grant_any & w_space & ~rst;
  assign w_out_xfer = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_chan   <= '0;
      r_last_grant <= SEL_W'(CHANNELS - 1);
    end else if (w_in_xfer) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_sel_data;
      r_out_chan   <= w_grant_idx;
      r_last_grant <= w_grant_idx;
    end else if (w_out_xfer) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign bus.in_ready   = w_grant & {CHANNELS{w_space & ~rst}};
  assign bus.out_data   = r_out_data;
  assign bus.out_chan   = r_out_chan;
  assign bus.out_valid  = r_out_valid;
  assign bus.last_grant = r_last_grant;

endmodule

// File: tb/tb_rr_operand_mux.sv
// Directed bench for rr_operand_mux: a 4-channel instance with a scoreboard
// of expected {chan,data} entries, plus a 3-channel instance for bad sel.
module tb_rr_operand_mux;
  localparam int WIDTH = 8;
  localparam int CH    = 4;
  localparam int SEL_W = 2;
  localparam int W     = SEL_W + WIDTH;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [W-1:0] exp_q[$];

  rr_operand_mux_if #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SEL_W)) bus ();
  rr_operand_mux_if #(.WIDTH(WIDTH), .CHANNELS(3),  .SEL_W(SEL_W)) bus3 ();

  rr_operand_mux #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  rr_operand_mux #(.WIDTH(WIDTH), .CHANNELS(3), .SEL_W(SEL_W)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] d);
    bus.in_data[k*WIDTH +: WIDTH] = d;
  endtask

  // One clock cycle: check comb in_ready, retire/record scoreboard entries
  // from the bench's own model, advance past the edge, check out_valid.
  task automatic cycle(input logic [CH-1:0] exp_rdy, input string tag);
    logic [W-1:0] e;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    if ((exp_q.size() != 0) && bus.out_ready) begin
      e = exp_q.pop_front();
      chk({tag, ".out_chan"}, 32'(bus.out_chan), 32'(e[W-1:WIDTH]));
      chk({tag, ".out_data"}, 32'(bus.out_data), 32'(e[WIDTH-1:0]));
    end
    for (int k = 0; k < CH; k++)
      if (exp_rdy[k] && bus.in_valid[k])
        exp_q.push_back({SEL_W'(k), bus.in_data[k*WIDTH +: WIDTH]});
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_q.size() != 0));
  endtask

  task automatic fill_random();
    for (int k = 0; k < CH; k++) set_ch(k, WIDTH'($urandom_range(0, 255)));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.mode = 1'b0;  bus.sel = '0;  bus.in_data = '0;
    bus.in_valid = '1; bus.out_ready = 1'b1;
    bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.in_data = 24'h332211;
    bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready",   32'(bus.in_ready),   0);
    chk("rst.out_valid",  32'(bus.out_valid),  0);
    chk("rst.out_data",   32'(bus.out_data),   0);
    chk("rst.out_chan",   32'(bus.out_chan),   0);
    chk("rst.last_grant", 32'(bus.last_grant), CH - 1);
    rst = 1'b0;

    // 1: fixed select of channel 2
    bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b0100;
    set_ch(2, 8'hA5);
    cycle(4'b0100, "t1.load");
    chk("t1.out_data", 32'(bus.out_data), 32'h A5);
    chk("t1.out_chan", 32'(bus.out_chan), 2);
    bus.in_valid = 4'b0000;
    cycle(4'b0000, "t1.drain");

    // 2: round-robin, all valid, full throughput from reset
    rst = 1'b1; #2; rst = 1'b0;
    bus.mode = 1'b1; bus.in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      fill_random();
      cycle(4'(1 << (i % CH)), "t2.rr");
    end
    bus.in_valid = 4'b0000;
    cycle(4'b0000, "t2.drain");

    // 3: round-robin over channels 1 and 3 starting from last_grant=1
    bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 4'b0010;
    set_ch(1, 8'h11);
    cycle(4'b0010, "t3.seed");
    chk("t3.last_grant", 32'(bus.last_grant), 1);
    bus.mode = 1'b1; bus.in_valid = 4'b1010;
    fill_random();
    cycle(4'b1000, "t3.g3a");
    fill_random();
    cycle(4'b0010, "t3.g1");
    fill_random();
    cycle(4'b1000, "t3.g3b");
    bus.in_valid = 4'b0000;
    cycle(4'b0000, "t3.drain");

    // 4: backpressure holds the entry, then load-while-drain
    bus.mode = 1'b0; bus.sel = 2'd0; bus.in_valid = 4'b0001;
    bus.out_ready = 1'b0;
    set_ch(0, 8'h3C);
    cycle(4'b0001, "t4.load");
    set_ch(0, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0000, "t4.stall");
      chk("t4.hold_data", 32'(bus.out_data), 32'h3C);
      chk("t4.hold_chan", 32'(bus.out_chan), 0);
    end
    bus.sel = 2'd2;
    chk("t4.stall_lg", 32'(bus.last_grant), 0);
    bus.sel = 2'd0; bus.out_ready = 1'b1;
    cycle(4'b0001, "t4.reload");
    chk("t4.new_data", 32'(bus.out_data), 32'hFF);
    bus.in_valid = 4'b0000;
    cycle(4'b0000, "t4.drain");

    // 5: out-of-range select on the 3-channel instance never grants
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5.in_ready", 32'(bus3.in_ready), 0);
      @(posedge clk); #1;
      chk("t5.out_valid", 32'(bus3.out_valid), 0);
    end
    bus3.sel = 2'd2;
    #1;
    chk("t5.sel2_rdy", 32'(bus3.in_ready), 32'h4);
    @(posedge clk); #1;
    chk("t5.sel2_data", 32'(bus3.out_data), 32'h33);
    chk("t5.sel2_chan", 32'(bus3.out_chan), 2);

    // 6: async reset discards a held entry; round-robin restarts at 0
    bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 4'b0010;
    set_ch(1, 8'h77);
    cycle(4'b0010, "t6.load");
    bus.out_ready = 1'b0; bus.in_valid = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    chk("t6.rst_valid", 32'(bus.out_valid),  0);
    chk("t6.rst_lg",    32'(bus.last_grant), CH - 1);
    chk("t6.rst_rdy",   32'(bus.in_ready),   0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
    fill_random();
    cycle(4'b0001, "t6.first");
    chk("t6.first_chan", 32'(bus.out_chan), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rr_operand_mux.md
Name: rr_operand_mux

Overview:
Parametrised, registered N:1 operand selector that feeds the Booth multiplier datapath. Generalises the fixed 2:1/4:1 combinational selectors to CHANNELS inputs of WIDTH bits each. Adds per-channel valid/ready handshakes, a fixed-select or round-robin arbitration mode, and a one-entry output register with backpressure. It sits between the operand sources (register file, constant/negation paths) and the multiplicand/multiplier load port.

Parameters:
WIDTH, 8, data width of each channel and of out_data
CHANNELS, 4, number of input channels; legal range 2..16
SEL_W, 2, select/channel-index width; must equal ceil(log2(CHANNELS))

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
mode  input  1  0 = fixed select via sel; 1 = round-robin among valid channels
sel  input  SEL_W  channel index used when mode=0
in_data  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel data valid
in_ready  output  CHANNELS  per-channel accept; a transfer on channel k occurs when in_valid[k] and in_ready[k] are both high
out_data  output  WIDTH  registered selected data
out_chan  output  SEL_W  index of the channel that supplied out_data
out_valid  output  1  out_data/out_chan hold a valid entry
out_ready  input  1  downstream accept; an output transfer occurs when out_valid and out_ready are both high

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_chan=0, last_grant=CHANNELS-1, so channel 0 has highest priority. in_ready is all-zero while rst=1.
- space = ~out_valid | out_ready. The output register can load in the same cycle it is drained, which gives full throughput of 1 transfer/cycle.
- Grant (combinational, at most one-hot):
  - mode=0: grant = channel sel if in_valid[sel] is high and sel < CHANNELS; otherwise no grant.
  - mode=1: grant goes to the first valid channel searching last_grant+1, last_grant+2, ... with wrap-around modulo CHANNELS. If no channel is valid, there is no grant.
- in_ready[k] = grant[k] & space & ~rst. A channel that is not granted sees in_ready=0 even when its in_valid is high.
- On an input transfer: out_data <= in_data of the granted channel, out_chan <= its index, out_valid <= 1, last_grant <= its index. last_grant updates in both modes.
- Output transfer with no input transfer in the same cycle: out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous output transfer and input transfer: the register is replaced by the new entry and out_valid stays 1. No bubble is inserted.
- Stall (out_valid=1, out_ready=0): out_data, out_chan and out_valid hold. No in_ready is asserted and last_grant does not change.
- Latency: 1 cycle from input transfer to out_valid.
- Changes to mode or sel affect only the next grant. A held output entry is never altered.
- Out-of-range sel (sel >= CHANNELS) in mode=0: no grant, no transfer, no error flag.
- Reset asserted mid-operation: the pending output entry is discarded immediately (out_valid=0) and last_grant returns to CHANNELS-1.
- No combinational path from in_valid to out_valid. There is a combinational path from out_ready to in_ready, which is permitted.
- All data is treated as opaque bits; no sign extension or arithmetic is performed.

Test Plan:
1. Defaults, mode=0, sel=2, in_valid=4'b0100, channel 2 data=8'hA5, out_ready=1 -> in_ready=4'b0100 in the same cycle; the next cycle gives out_valid=1, out_data=8'hA5, out_chan=2.
2. mode=1, all four channels valid and continuously refilled, out_ready=1, after reset -> out_chan sequence 0,1,2,3,0 on consecutive cycles, with no idle cycles.
3. mode=1, in_valid=4'b1010, last_grant=1 -> grant goes to 3, then 1, then 3; channels 0 and 2 never see in_ready.
4. Backpressure: out_valid=1 with out_data=8'h3C, out_ready=0 for 3 cycles while channel 0 is valid with 8'hFF -> out_data stays 8'h3C and in_ready stays 0. When out_ready rises, 8'hFF loads in that same cycle and out_valid stays 1.
5. mode=0, sel=3, CHANNELS=3 (SEL_W=2), all channels valid -> in_ready=0 and out_valid stays 0 indefinitely.
6. rst pulsed asynchronously mid-cycle while out_valid=1 and out_ready=0 -> out_valid=0 immediately. After release in mode=1 with all channels valid, the first grant is channel 0.
